// File: rtl/uart_8n1_reg_bridge_pkg.sv
// rtl/uart_8n1_reg_bridge_pkg.sv - opcodes, reply codes and FSM encoding for the UART register bridge
package uart_8n1_reg_bridge_pkg;

  typedef logic [7:0] byte_t;

  localparam byte_t OP_WRITE = 8'h57;
  localparam byte_t OP_READ  = 8'h52;
  localparam byte_t RSP_ACK  = 8'h06;
  localparam byte_t RSP_NAK  = 8'h15;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_GET_ADDR  = 3'd1;
  localparam logic [2:0] S_GET_DATA  = 3'd2;
  localparam logic [2:0] S_BUS       = 3'd3;
  localparam logic [2:0] S_SEND      = 3'd4;
  localparam logic [2:0] S_SEND_WAIT = 3'd5;

  function automatic logic is_cmd_op(input byte_t b);
    return (b == OP_WRITE) || (b == OP_READ);
  endfunction

endpackage

// File: rtl/uart_8n1_reg_bridge_if.sv
// rtl/uart_8n1_reg_bridge_if.sv - UART byte port and register bus seen by the bridge
interface uart_8n1_reg_bridge_if;
  logic [7:0] uart_rx_data;
  logic       uart_rx_full;
  logic       uart_rx_error;
  logic       uart_rx_read;
  logic [7:0] uart_tx_data;
  logic       uart_tx_write;
  logic       uart_tx_empty;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_req;
  logic [7:0] reg_rdata;
  logic       reg_ack;
  logic       busy;

  modport master (
    input  uart_rx_data, uart_rx_full, uart_rx_error, uart_tx_empty, reg_rdata, reg_ack,
    output uart_rx_read, uart_tx_data, uart_tx_write, reg_addr, reg_wdata, reg_we, reg_req, busy
  );

  modport slave (
    output uart_rx_data, uart_rx_full, uart_rx_error, uart_tx_empty, reg_rdata, reg_ack,
    input  uart_rx_read, uart_tx_data, uart_tx_write, reg_addr, reg_wdata, reg_we, reg_req, busy
  );
endinterface

// File: rtl/uart_8n1_reg_bridge_timeout_counter.sv
// rtl/uart_8n1_reg_bridge_timeout_counter.sv - saturating cycle counter, expired on the LIMIT-th enabled cycle
module uart_8n1_reg_bridge_timeout_counter #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear)
      cnt_d = '0;
    else if (enable && cnt_q != LAST)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired = enable && (cnt_q == LAST);
endmodule

// File: rtl/uart_8n1_reg_bridge.sv
// rtl/uart_8n1_reg_bridge.sv - turns 'W' addr data / 'R' addr UART commands into register bus accesses
module uart_8n1_reg_bridge
  import uart_8n1_reg_bridge_pkg::*;
#(
  parameter int BYTE_TIMEOUT_CYCLES = 1_000_000,
  parameter int BUS_TIMEOUT_CYCLES  = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  uart_8n1_reg_bridge_if.master     bus
);
  logic [2:0] state_q, state_d;
  byte_t      reg_addr_q, reg_addr_d;
  byte_t      reg_wdata_q, reg_wdata_d;
  logic       reg_we_q, reg_we_d;
  logic       reg_req_q, reg_req_d;
  byte_t      tx_data_q, tx_data_d;
  logic       tx_write_q, tx_write_d;

  logic accept, in_get, byte_expired, bus_expired;

  assign accept = bus.uart_rx_full && !bus.uart_rx_error;
  assign in_get = (state_q == S_GET_ADDR) || (state_q == S_GET_DATA);

  uart_8n1_reg_bridge_timeout_counter #(.LIMIT(BYTE_TIMEOUT_CYCLES)) u_byte_tmo (
    .clk(clk), .rst(reset), .clear(!in_get || accept), .enable(in_get), .expired(byte_expired)
  );

  uart_8n1_reg_bridge_timeout_counter #(.LIMIT(BUS_TIMEOUT_CYCLES)) u_bus_tmo (
    .clk(clk), .rst(reset), .clear(!reg_req_q), .enable(reg_req_q), .expired(bus_expired)
  );

  always_comb begin
    state_d     = state_q;
    reg_addr_d  = reg_addr_q;
    reg_wdata_d = reg_wdata_q;
    reg_we_d    = reg_we_q;
    reg_req_d   = reg_req_q;
    tx_data_d   = tx_data_q;
    tx_write_d  = 1'b0;
    case (state_q)
      S_IDLE: if (accept) begin
        reg_we_d = (bus.uart_rx_data == OP_WRITE);
        if (is_cmd_op(bus.uart_rx_data)) begin
          state_d = S_GET_ADDR;
        end else begin
          tx_data_d = RSP_NAK;
          state_d   = S_SEND;
        end
      end
      S_GET_ADDR: begin
        if (bus.uart_rx_error) begin
          state_d = S_IDLE;
        end else if (accept) begin
          reg_addr_d = bus.uart_rx_data;
          if (reg_we_q) begin
            state_d = S_GET_DATA;
          end else begin
            reg_req_d = 1'b1;
            state_d   = S_BUS;
          end
        end else if (byte_expired) begin
          state_d = S_IDLE;
        end
      end
      S_GET_DATA: begin
        if (bus.uart_rx_error) begin
          state_d = S_IDLE;
        end else if (accept) begin
          reg_wdata_d = bus.uart_rx_data;
          reg_req_d   = 1'b1;
          state_d     = S_BUS;
        end else if (byte_expired) begin
          state_d = S_IDLE;
        end
      end
      // An ack in the same cycle as the timeout still wins.
      S_BUS: begin
        if (reg_req_q && bus.reg_ack) begin
          reg_req_d = 1'b0;
          tx_data_d = reg_we_q ? RSP_ACK : bus.reg_rdata;
          state_d   = S_SEND;
        end else if (bus_expired) begin
          reg_req_d = 1'b0;
          tx_data_d = RSP_NAK;
          state_d   = S_SEND;
        end
      end
      S_SEND: if (bus.uart_tx_empty) begin
        tx_write_d = 1'b1;
        state_d    = S_SEND_WAIT;
      end
      // tx_write_q is high only in the first SEND_WAIT cycle, when empty is still stale.
      S_SEND_WAIT: if (!tx_write_q && bus.uart_tx_empty) begin
        tx_data_d = '0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      reg_addr_q  <= '0;
      reg_wdata_q <= '0;
      reg_we_q    <= 1'b0;
      reg_req_q   <= 1'b0;
      tx_data_q   <= '0;
      tx_write_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      reg_addr_q  <= reg_addr_d;
      reg_wdata_q <= reg_wdata_d;
      reg_we_q    <= reg_we_d;
      reg_req_q   <= reg_req_d;
      tx_data_q   <= tx_data_d;
      tx_write_q  <= tx_write_d;
    end
  end

  assign bus.uart_rx_read  = bus.uart_rx_full;
  assign bus.uart_tx_data  = tx_data_q;
  assign bus.uart_tx_write = tx_write_q;
  assign bus.reg_addr      = reg_addr_q;
  assign bus.reg_wdata     = reg_wdata_q;
  assign bus.reg_we        = reg_we_q;
  assign bus.reg_req       = reg_req_q;
  assign bus.busy          = (state_q != S_IDLE);
endmodule

// File: doc/uart_8n1_reg_bridge.md
Name: uart_8n1_reg_bridge

Overview:
Host-facing client of the uart_8n1 byte interface. It consumes received bytes as a 2- or 3-byte command stream, executes 8-bit register reads/writes on a simple req/ack register bus, and writes a single reply byte back through the UART transmit port. It sits between uart_8n1 and on-chip control/status registers, giving a PC-side debug path into the design.

Parameters:
BYTE_TIMEOUT_CYCLES, 1_000_000, max clk cycles between bytes of one command before the partial command is discarded
BUS_TIMEOUT_CYCLES, 255, max clk cycles waiting for reg_ack before the access is abandoned with NAK

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  asynchronous, active-high reset
uart_rx_data  input  8  received byte from uart_8n1 (rx_data)
uart_rx_full  input  1  one-cycle strobe, uart_rx_data valid (rx_full)
uart_rx_error  input  1  framing error flag from uart_8n1 (rx_error)
uart_rx_read  output  1  acknowledge of consumed byte (rx_read)
uart_tx_data  output  8  reply byte to uart_8n1 (tx_data)
uart_tx_write  output  1  one-cycle write strobe (tx_write)
uart_tx_empty  input  1  uart_8n1 holding register empty (tx_empty)
reg_addr  output  8  register address
reg_wdata  output  8  register write data
reg_we  output  1  1 = write, 0 = read; valid while reg_req
reg_req  output  1  access request, held until reg_ack or bus timeout
reg_rdata  input  8  read data, sampled in the cycle reg_ack is high
reg_ack  input  1  access complete
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (async assert, sync release): state IDLE; all outputs 0; timers cleared.
- Command set: 0x57 ('W') addr data -> write, reply 0x06 (ACK). 0x52 ('R') addr -> read, reply read data. Any other opcode byte -> reply 0x15 (NAK) immediately, no bus access.
- Byte intake: byte accepted in any cycle uart_rx_full=1 and uart_rx_error=0 while in IDLE/GET_ADDR/GET_DATA; uart_rx_read pulses high in that same cycle; uart_rx_data captured that cycle.
- uart_rx_full while in BUS/SEND/SEND_WAIT: byte dropped, uart_rx_read still pulsed (bridge never stalls receiver).
- uart_rx_error=1 in any intake state: return to IDLE, discard partial command, no reply.
- States: IDLE -(W/R)-> GET_ADDR; IDLE -(other)-> SEND(NAK). GET_ADDR -(byte, op W)-> GET_DATA; -(byte, op R)-> BUS. GET_DATA -(byte)-> BUS. BUS -(reg_ack)-> SEND; -(bus timeout)-> SEND(NAK). SEND -> SEND_WAIT. SEND_WAIT -(uart_tx_empty)-> IDLE.
- Byte timeout: counter cleared on every accepted byte; in GET_ADDR/GET_DATA reaching BYTE_TIMEOUT_CYCLES -> IDLE, no reply.
- BUS: reg_req asserted first cycle after entry, reg_addr/reg_wdata/reg_we stable while reg_req=1; reg_req drops the cycle after reg_ack sampled high. Read reply = reg_rdata sampled at reg_ack. reg_ack with reg_req=0 ignored.
- Bus timeout: reg_req high for BUS_TIMEOUT_CYCLES cycles without reg_ack -> drop reg_req, reply NAK.
- SEND: waits for uart_tx_empty=1, then one-cycle uart_tx_write with uart_tx_data; uart_tx_data held until back in IDLE. SEND_WAIT ignores uart_tx_empty in its first cycle (uart_8n1 sets full one cycle after write), then waits for empty.
- Latency: last command byte strobe -> reg_req 1 cycle; reg_ack -> uart_tx_write 2 cycles when tx empty.
- Counters saturate; no wrap. Timeout widths derived with $clog2.

Decomposition:
- Shared package/header: opcode constants (OP_WRITE 0x57, OP_READ 0x52), reply constants (RSP_ACK 0x06, RSP_NAK 0x15), state encoding.
- No sub-module required; optional generic uart_8n1_timeout_counter (clear/enable/expired) instantiated twice.

Test Plan:
- Bytes 0x57,0x10,0xA5 -> one reg_req with reg_we=1, reg_addr=0x10, reg_wdata=0xA5; reg_ack after 3 cycles -> uart_tx_write with 0x06.
- Bytes 0x52,0x22, reg_ack with reg_rdata=0x3C -> reg_we=0, reg_addr=0x22; reply 0x3C; uart_rx_read pulsed for each byte.
- Byte 0x41 -> no reg_req; reply 0x15; busy returns low after uart_tx_empty.
- 0x57,0x10 then no byte for BYTE_TIMEOUT_CYCLES (set 100) -> IDLE, no reply; next 0x52,0x01 executes normally.
- Read with reg_ack never asserted, BUS_TIMEOUT_CYCLES=8 -> reg_req high exactly 8 cycles, reply 0x15.
- uart_tx_empty held 0 for 50 cycles in SEND -> no uart_tx_write until empty; reset asserted mid-BUS -> reg_req, busy low asynchronously.
